// File: rtl/mem_dma_pkg.sv
`default_nettype none
// ============================================================================
// mem_dma_pkg
// Shared definitions for the block-transfer initiator: FSM state encoding,
// transfer mode constants and default memory widths (shared with the
// memory and the CPU core).
// Revision: 1.0
// ============================================================================
package mem_dma_pkg;

  // Default widths of the processor data memory port
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Transfer modes as presented on the mode input
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : mem_dma_pkg
`default_nettype wire

// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
// mem_dma
// Block-transfer initiator for the single-port data memory. Performs either
// an ascending byte copy (src -> dst, read/write alternating) or a constant
// fill of len bytes, then pulses done for one cycle. All outputs come
// straight from flops, so there is no combinational path from the request
// inputs (or from mem_dout) to the memory port.
// Revision: 1.0
// ============================================================================
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  // Control and datapath registers
  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   src_ptr_q,  src_ptr_d;
  logic [ADDR_W-1:0]   dst_ptr_q,  dst_ptr_d;
  logic [ADDR_W-1:0]   remain_q,   remain_d;
  logic [DATA_W-1:0]   data_q,     data_d;
  logic                mode_q,     mode_d;
  logic [DATA_W-1:0]   fill_val_q, fill_val_d;

  // Output registers; their next values are decoded from the next state
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q,  mem_din_d;

  // Next-state, datapath update and registered-output decode
  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    remain_d   = remain_q;
    data_d     = data_q;
    mode_d     = mode_q;
    fill_val_d = fill_val_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_ptr_d  = src_addr;
          dst_ptr_d  = dst_addr;
          remain_d   = len;
          mode_d     = mode;
          fill_val_d = fill_val;
          if (len == ADDR_ZERO) begin
            state_d = ST_DONE;
          end else if (mode == MODE_FILL) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        // Memory read data is combinational from the source address
        data_d    = mem_dout;
        src_ptr_d = src_ptr_q + ADDR_ONE;
        state_d   = ST_WRITE;
      end

      ST_WRITE: begin
        dst_ptr_d = dst_ptr_q + ADDR_ONE;
        remain_d  = remain_q - ADDR_ONE;
        if (remain_q == ADDR_ONE) begin
          state_d = ST_DONE;
        end else if (mode_q == MODE_FILL) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs for the cycle spent in state_d, computed one edge early
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    mem_we_d   = (state_d == ST_WRITE);
    mem_addr_d = ADDR_ZERO;
    mem_din_d  = DATA_ZERO;
    if (state_d == ST_READ) begin
      mem_addr_d = src_ptr_d;
    end else if (state_d == ST_WRITE) begin
      mem_addr_d = dst_ptr_d;
      mem_din_d  = (mode_d == MODE_FILL) ? fill_val_d : data_d;
    end
  end

  // State, datapath and output registers; reset abandons any transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_ptr_q  <= ADDR_ZERO;
      dst_ptr_q  <= ADDR_ZERO;
      remain_q   <= ADDR_ZERO;
      data_q     <= DATA_ZERO;
      mode_q     <= MODE_COPY;
      fill_val_q <= DATA_ZERO;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= ADDR_ZERO;
      mem_din_q  <= DATA_ZERO;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      remain_q   <= remain_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      fill_val_q <= fill_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule : mem_dma
`default_nettype wire

// File: tb/tb_mem_dma.sv
`default_nettype none
// ============================================================================
// tb_mem_dma
// Self-checking bench for mem_dma. A behavioural single-port memory sits on
// the DMA port. For each transfer a reference memory image predicts the
// per-cycle memory port activity (pushed to a queue when the request is
// driven, popped as the DUT runs), the done latency and the final memory
// contents.
// Revision: 1.0
// ============================================================================
module tb_mem_dma;
  import mem_dma_pkg::*;

  typedef struct {
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] fill;
    int         done_cyc;
    int         glitch;
  } vec_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } xfer_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] len;
  logic [7:0] fill_val;
  logic       busy;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic       mem_we;
  logic [7:0] mem_dout;

  logic       init_mem;
  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];

  xfer_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  vec_t  vecs[7];

  mem_dma #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .fill_val (fill_val),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      0:       return 8'hA1;
      1:       return 8'hB2;
      2:       return 8'hC3;
      3:       return 8'hD4;
      default: return 8'((i * 7 + 3) & 255);
    endcase
  endfunction

  // Behavioural memory: combinational read, write at the rising edge
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic check_mem_image(input string name);
    int n = 0;
    int first = -1;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        n++;
        if (first < 0) first = i;
      end
    end
    chk(n == 0, name, $sformatf("%0d bytes differ, first at 0x%02h (got %02h want %02h)",
        n, first[7:0], (first >= 0) ? mem[first[7:0]] : 8'h00,
        (first >= 0) ? ref_mem[first[7:0]] : 8'h00));
  endtask

  task automatic run_xfer(input vec_t v, input string name);
    xfer_t e;
    bit    done_seen = 0;
    int    budget = 2 * int'(v.len) + 4;
    // Predict the memory port activity, one entry per transfer cycle
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      logic [7:0] ra = v.src + 8'(i);
      logic [7:0] wa = v.dst + 8'(i);
      logic [7:0] d;
      if (v.mode == MODE_COPY) begin
        exp_q.push_back('{1'b0, ra, 8'h00});
        d = ref_mem[ra];
      end else begin
        d = v.fill;
      end
      exp_q.push_back('{1'b1, wa, d});
      ref_mem[wa] = d;
    end

    @(negedge clk);
    start = 1'b1; mode = v.mode; src_addr = v.src; dst_addr = v.dst;
    len = v.len; fill_val = v.fill;
    @(posedge clk); #1;
    // Request inputs are scrambled after acceptance; they must not matter
    start = 1'b0; src_addr = 8'($urandom); dst_addr = 8'($urandom);
    len = 8'($urandom); fill_val = 8'($urandom); mode = 1'($urandom);

    for (int c = 1; c <= budget; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (done) begin
        chk(c == v.done_cyc && busy && !mem_we, {name, "_done"},
            $sformatf("done at cycle %0d busy=%b we=%b, want cycle %0d busy=1 we=0",
                      c, busy, mem_we, v.done_cyc));
        done_seen = 1;
        break;
      end
      if (!busy) begin
        chk(1'b0, {name, "_busy"}, $sformatf("busy low at cycle %0d before done", c));
        break;
      end
      if (exp_q.size() == 0) begin
        chk(1'b0, {name, "_extra"}, $sformatf("unexpected cycle %0d we=%b addr=%02h",
            c, mem_we, mem_addr));
      end else begin
        e = exp_q.pop_front();
        chk(mem_we === e.we && mem_addr === e.addr && (!e.we || mem_din === e.data),
            {name, "_port"},
            $sformatf("cycle %0d got we=%b addr=%02h din=%02h, want we=%b addr=%02h din=%02h",
                      c, mem_we, mem_addr, mem_din, e.we, e.addr, e.data));
      end
      // A start pulse with other arguments while busy must be ignored
      if (v.glitch != 0 && c == v.glitch) begin
        start = 1'b1; mode = ~v.mode; src_addr = 8'h99; dst_addr = 8'hC0;
        len = 8'd2; fill_val = 8'hEE;
      end
      if (v.glitch != 0 && c == v.glitch + 1) start = 1'b0;
    end
    if (!done_seen) chk(1'b0, {name, "_timeout"}, $sformatf("no done within %0d cycles", budget));
    chk(exp_q.size() == 0, {name, "_missing"}, $sformatf("%0d predicted cycles not seen", exp_q.size()));
    exp_q.delete();
    start = 1'b0;
    @(posedge clk); #1;
    chk(!busy && !done && !mem_we && mem_addr == 8'h00 && mem_din == 8'h00, {name, "_idle"},
        $sformatf("busy=%b done=%b we=%b addr=%02h din=%02h, want all 0",
                  busy, done, mem_we, mem_addr, mem_din));
    check_mem_image({name, "_mem"});
  endtask

  initial begin
    //        mode       src    dst    len   fill   done glitch
    vecs[0] = '{MODE_COPY, 8'h00, 8'h10, 8'd4, 8'h00, 9, 0};
    vecs[1] = '{MODE_FILL, 8'h00, 8'h20, 8'd3, 8'h5A, 4, 0};
    vecs[2] = '{MODE_COPY, 8'h33, 8'h44, 8'd0, 8'h00, 1, 0};
    vecs[3] = '{MODE_COPY, 8'hFE, 8'h0E, 8'd4, 8'h00, 9, 0};
    vecs[4] = '{MODE_COPY, 8'h30, 8'h60, 8'd3, 8'h00, 7, 3};
    vecs[5] = '{MODE_COPY, 8'h40, 8'h41, 8'd3, 8'h00, 7, 0};
    vecs[6] = '{MODE_FILL, 8'h00, 8'hFD, 8'd5, 8'h3C, 6, 2};

    rst = 1'b1; init_mem = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = 8'h00; dst_addr = 8'h00; len = 8'h00; fill_val = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    @(posedge clk); #1;
    init_mem = 1'b0;
    chk(!busy && !done && !mem_we && mem_addr == 8'h00 && mem_din == 8'h00, "reset_outputs",
        $sformatf("busy=%b done=%b we=%b addr=%02h din=%02h, want all 0",
                  busy, done, mem_we, mem_addr, mem_din));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_mem_image("init_mem");

    for (int k = 0; k < 7; k++) run_xfer(vecs[k], $sformatf("vec%0d", k));

    // Reset in the middle of a copy, after two bytes have been written
    @(negedge clk);
    start = 1'b1; mode = MODE_COPY; src_addr = 8'h40; dst_addr = 8'h50; len = 8'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk(busy && !mem_we && mem_addr == 8'h42, "rst_pre",
        $sformatf("busy=%b we=%b addr=%02h, want busy=1 we=0 addr=42", busy, mem_we, mem_addr));
    rst = 1'b1;
    #1;
    chk(!busy && !done && !mem_we && mem_addr == 8'h00 && mem_din == 8'h00, "rst_async",
        $sformatf("busy=%b done=%b we=%b addr=%02h din=%02h, want all 0",
                  busy, done, mem_we, mem_addr, mem_din));
    ref_mem[8'h50] = ref_mem[8'h40];
    ref_mem[8'h51] = ref_mem[8'h41];
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk(!busy, "rst_stays_idle", $sformatf("busy=%b after reset release, want 0", busy));
    check_mem_image("rst_mem");

    run_xfer('{MODE_COPY, 8'h70, 8'h80, 8'd2, 8'h00, 5, 0}, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_dma
`default_nettype wire
